// File: rtl/muldiv_arbiter.sv
// rtl/muldiv_arbiter.sv - two-hart round-robin front end for a shared single-issue mul/div unit
module muldiv_arbiter #(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [5:0]              req_op,
    input  logic [2*XLEN-1:0]       req_a,
    input  logic [2*XLEN-1:0]       req_b,
    input  logic [2*REG_ADDR_W-1:0] req_rd,
    input  logic [1:0]              flush,
    output logic                    muldiv_start,
    output logic [2:0]              muldiv_op,
    output logic [XLEN-1:0]         muldiv_a,
    output logic [XLEN-1:0]         muldiv_b,
    output logic                    muldiv_hart_id,
    output logic [REG_ADDR_W-1:0]   muldiv_rd,
    input  logic                    muldiv_busy,
    input  logic                    muldiv_done,
    input  logic [XLEN-1:0]         muldiv_result,
    input  logic                    muldiv_done_hart_id,
    input  logic [REG_ADDR_W-1:0]   muldiv_done_rd,
    output logic [1:0]              resp_valid,
    output logic [XLEN-1:0]         resp_result,
    output logic [REG_ADDR_W-1:0]   resp_rd,
    output logic                    err_timeout,
    output logic                    err_spurious
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYC);

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    killed_q, killed_d;
    logic [2:0]              op_q, op_d;
    logic [XLEN-1:0]         a_q, a_d, b_q, b_d;
    logic                    hart_q, hart_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [1:0]              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]         resp_result_q, resp_result_d;
    logic [REG_ADDR_W-1:0]   resp_rd_q, resp_rd_d;
    logic                    err_t_q, err_t_d, err_s_q, err_s_d;

    logic                    grant_hart;
    logic                    flush_cur;
    logic                    match_done;
    logic                    kill_now;

    // With both harts requesting, the one not served last wins.
    assign grant_hart = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    assign req_ready  = (state_q == IDLE) ?
                        (req_valid & (grant_hart ? 2'b10 : 2'b01)) : 2'b00;

    assign flush_cur    = flush[hart_q];
    assign match_done   = muldiv_done && (state_q == WAIT) && (muldiv_done_hart_id == hart_q);
    assign kill_now     = killed_q | flush_cur;
    assign muldiv_start = (state_q == ISSUE) && !muldiv_busy && !flush_cur;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        killed_d      = killed_q;
        op_d          = op_q;
        a_d           = a_q;
        b_d           = b_q;
        hart_d        = hart_q;
        rd_d          = rd_q;
        resp_valid_d  = 2'b00;
        resp_result_d = resp_result_q;
        resp_rd_d     = resp_rd_q;
        err_t_d       = err_t_q;
        err_s_d       = err_s_q | (muldiv_done && !match_done);

        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    op_d         = req_op[3*grant_hart +: 3];
                    a_d          = req_a[XLEN*grant_hart +: XLEN];
                    b_d          = req_b[XLEN*grant_hart +: XLEN];
                    rd_d         = req_rd[REG_ADDR_W*grant_hart +: REG_ADDR_W];
                    hart_d       = grant_hart;
                    last_grant_d = grant_hart;
                    killed_d     = 1'b0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (flush_cur) begin
                    state_d = IDLE;
                end else if (!muldiv_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A killed op still drains through the unit; only the response is suppressed.
                killed_d = kill_now;
                if (match_done) begin
                    resp_valid_d[hart_q] = !kill_now;
                    if (!kill_now) begin
                        resp_result_d = muldiv_result;
                        resp_rd_d     = muldiv_done_rd;
                    end
                    state_d = IDLE;
                end else if (cnt_q == TMO) begin
                    err_t_d              = 1'b1;
                    resp_valid_d[hart_q] = !kill_now;
                    if (!kill_now) begin
                        resp_result_d = '1;
                        resp_rd_d     = rd_q;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
            killed_q      <= 1'b0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            hart_q        <= 1'b0;
            rd_q          <= '0;
            resp_valid_q  <= 2'b00;
            resp_result_q <= '0;
            resp_rd_q     <= '0;
            err_t_q       <= 1'b0;
            err_s_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            killed_q      <= killed_d;
            op_q          <= op_d;
            a_q           <= a_d;
            b_q           <= b_d;
            hart_q        <= hart_d;
            rd_q          <= rd_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_rd_q     <= resp_rd_d;
            err_t_q       <= err_t_d;
            err_s_q       <= err_s_d;
        end
    end

    assign muldiv_op      = op_q;
    assign muldiv_a       = a_q;
    assign muldiv_b       = b_q;
    assign muldiv_hart_id = hart_q;
    assign muldiv_rd      = rd_q;
    assign resp_valid     = resp_valid_q;
    assign resp_result    = resp_result_q;
    assign resp_rd        = resp_rd_q;
    assign err_timeout    = err_t_q;
    assign err_spurious   = err_s_q;

endmodule
